// File: rtl/relu_backward.sv
`default_nettype none
// ============================================================================
//  Module   : relu_backward
//  Purpose  : Backward pass of a ReLU layer over a MAP_WIDTH x MAP_WIDTH map
//             of signed 32-bit elements. After a start request, one element
//             per clock is processed in row-major order. Each downstream
//             gradient is the upstream gradient where the forward-pass input
//             was strictly positive. Elsewhere it is zero, or the leaky
//             gradient (grad_in >>> 3) when RELU_BWD_LEAKY_EN is defined.
//
//  Macro    : RELU_BWD_LEAKY_EN - when defined, non-positive elements pass
//             grad_in >>> 3 (slope 1/8, rounds toward minus infinity)
//             instead of zero.
//
//  Ports    :
//    clk          in   1      rising-edge clock
//    rst          in   1      asynchronous active-high reset
//    start        in   1      pass request, honoured in IDLE or DONE
//    pre_act_map  in   N*32   forward ReLU input,  element k at [k*32 +: 32]
//    grad_in_map  in   N*32   upstream gradient,   same packing
//    grad_out_map out  N*32   downstream gradient, same packing (registered)
//    busy         out  1      pass in progress
//    done         out  1      pass finished, held until next start or reset
//    (N = MAP_WIDTH * MAP_WIDTH, legal MAP_WIDTH range 1..64)
//
//  Revision : 1.0  initial release
// ============================================================================
module relu_backward #(
  parameter int MAP_WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [MAP_WIDTH*MAP_WIDTH*32-1:0]  pre_act_map,
  input  logic [MAP_WIDTH*MAP_WIDTH*32-1:0]  grad_in_map,
  output logic [MAP_WIDTH*MAP_WIDTH*32-1:0]  grad_out_map,
  output logic                               busy,
  output logic                               done
);

  localparam int c_NUM_ELEM = MAP_WIDTH * MAP_WIDTH;
  // A one-element map still needs a one-bit index so the counter is legal.
  localparam int c_IDX_W    = (c_NUM_ELEM > 1) ? $clog2(c_NUM_ELEM) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NUM_ELEM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_accept;
  logic                w_last;
  logic [c_IDX_W-1:0]  r_idx;

  logic signed [31:0]  w_pre_elem  [c_NUM_ELEM];
  logic signed [31:0]  w_grad_elem [c_NUM_ELEM];
  logic signed [31:0]  r_grad_out  [c_NUM_ELEM];

  logic signed [31:0]  w_pre_sel;
  logic signed [31:0]  w_grad_sel;
  logic signed [31:0]  w_gated;
  logic signed [31:0]  w_result;
  logic                w_positive;

  // --------------------------------------------------------------------------
  // Unpack the flat input buses and repack the registered result.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < c_NUM_ELEM; k++) begin : g_elem
      assign w_pre_elem[k]               = pre_act_map[k*32 +: 32];
      assign w_grad_elem[k]              = grad_in_map[k*32 +: 32];
      assign grad_out_map[k*32 +: 32]    = r_grad_out[k];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Element datapath: only the element addressed by r_idx is evaluated.
  // Zero counts as non-positive, so the strict signed compare gates it.
  // --------------------------------------------------------------------------
  assign w_pre_sel  = w_pre_elem[r_idx];
  assign w_grad_sel = w_grad_elem[r_idx];
  assign w_positive = (w_pre_sel > 32'sd0);

`ifdef RELU_BWD_LEAKY_EN
  // Arithmetic shift keeps the sign; result magnitude never exceeds the input.
  assign w_gated = w_grad_sel >>> 3;
`else
  assign w_gated = 32'sd0;
`endif

  assign w_result = w_positive ? w_grad_sel : w_gated;

  // --------------------------------------------------------------------------
  // Control FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state. start is ignored while RUN, so a request held
  // high across a pass produces exactly one pass; a request still high in
  // DONE launches the next pass back-to-back.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_next = RUN;
          w_accept     = 1'b1;
        end
      end
      RUN: begin
        if (r_idx == c_LAST_IDX) begin
          w_state_next = DONE;
          w_last       = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Index counter and result registers. Elements not yet reached in the
  // current pass keep whatever the previous pass left there.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      for (int k = 0; k < c_NUM_ELEM; k++) begin
        r_grad_out[k] <= 32'sd0;
      end
    end else if (r_state == RUN) begin
      r_grad_out[r_idx] <= w_result;
      r_idx             <= w_last ? '0 : (r_idx + 1'b1);
    end else if (w_accept) begin
      r_idx <= '0;
    end
  end

  // Both flags decode from a single state register, so they are exclusive.
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_relu_backward.sv
`default_nettype none
// ============================================================================
//  Module   : tb_relu_backward
//  Purpose  : Self-checking bench for relu_backward. Three instances
//             (MAP_WIDTH 1, 2 and 4) cover directed corner cases and a
//             randomized 100-pass run checked against a pass-level model.
//             Honours RELU_BWD_LEAKY_EN for the expected gradients.
//  Revision : 1.0  initial release
// ============================================================================
module tb_relu_backward;

  // Expected literals for the gated (non-positive) path.
`ifdef RELU_BWD_LEAKY_EN
  localparam logic [31:0] c_EXP_G20  = 32'd2;          // 20 >>> 3
  localparam logic [31:0] c_EXP_G30  = 32'd3;          // 30 >>> 3
  localparam logic [31:0] c_EXP_GM9  = 32'hFFFF_FFFE;  // -9 >>> 3 = -2
  localparam logic [31:0] c_EXP_GMAX = 32'h0FFF_FFFF;  // 0x7FFFFFFF >>> 3
`else
  localparam logic [31:0] c_EXP_G20  = 32'd0;
  localparam logic [31:0] c_EXP_G30  = 32'd0;
  localparam logic [31:0] c_EXP_GM9  = 32'd0;
  localparam logic [31:0] c_EXP_GMAX = 32'd0;
`endif

  localparam int c_N4 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- DUT, map_width = 1 ----------------
  logic        rst1 = 1'b0, start1 = 1'b0;
  logic [31:0] pre1 = '0, gin1 = '0, gout1;
  logic        busy1, done1;
  relu_backward #(.MAP_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .pre_act_map(pre1),
    .grad_in_map(gin1), .grad_out_map(gout1), .busy(busy1), .done(done1));

  // ---------------- DUT, map_width = 2 ----------------
  logic         rst2 = 1'b0, start2 = 1'b0;
  logic [127:0] pre2 = '0, gin2 = '0, gout2;
  logic         busy2, done2;
  relu_backward #(.MAP_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .pre_act_map(pre2),
    .grad_in_map(gin2), .grad_out_map(gout2), .busy(busy2), .done(done2));

  // ---------------- DUT, map_width = 4 ----------------
  logic         rst4 = 1'b0, start4 = 1'b0;
  logic [511:0] pre4 = '0, gin4 = '0, gout4;
  logic         busy4, done4;
  relu_backward #(.MAP_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .pre_act_map(pre4),
    .grad_in_map(gin4), .grad_out_map(gout4), .busy(busy4), .done(done4));

  // ---------------- reference rule ----------------
  function automatic logic [31:0] ref_grad(input logic signed [31:0] p,
                                           input logic signed [31:0] g);
    if (p > 0) return g;
`ifdef RELU_BWD_LEAKY_EN
    return g >>> 3;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- pass-level model for the 16-element instance ----------------
  // A pass is a start seen while no pass is running; it then consumes one
  // element per clock in order, and finishes after the sixteenth.
  logic        m_active = 1'b0;
  logic        m_done   = 1'b0;
  int          m_k      = 0;
  logic [31:0] m_exp [c_N4] = '{default: 32'd0};
  logic        cmp_en   = 1'b0;

  always @(posedge clk or posedge rst4) begin
    if (rst4) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_k      = 0;
      for (int k = 0; k < c_N4; k++) m_exp[k] = 32'd0;
    end else if (m_active) begin
      m_exp[m_k] = ref_grad(pre4[m_k*32 +: 32], gin4[m_k*32 +: 32]);
      m_k++;
      if (m_k == c_N4) begin
        m_active = 1'b0;
        m_done   = 1'b1;
        m_k      = 0;
      end
    end else if (start4) begin
      m_active = 1'b1;
      m_done   = 1'b0;
      m_k      = 0;
    end
  end

  // Compare process: checked every cycle on the falling edge.
  int   busy_cnt  = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      int bad;
      chk("busy4", {31'd0, busy4}, {31'd0, m_active});
      chk("done4", {31'd0, done4}, {31'd0, m_done});
      bad = -1;
      for (int k = c_N4 - 1; k >= 0; k--) begin
        if (gout4[k*32 +: 32] !== m_exp[k]) bad = k;
      end
      n_vec++;
      if (bad >= 0) begin
        n_err++;
        $display("FAIL grad_out4[%0d]: got %08h expected %08h at %0t",
                 bad, gout4[bad*32 +: 32], m_exp[bad], $time);
      end
      if (rst4) begin
        busy_cnt = 0;
      end else if (busy4) begin
        busy_cnt++;
      end else if (prev_busy) begin
        chk("busy_cycles4", busy_cnt, 32'd16);
        busy_cnt = 0;
      end
      prev_busy = busy4 && !rst4;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n edges after acceptance on dut2, checking busy/done each edge.
  task automatic run2(input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      chk("busy2_run", {31'd0, busy2}, {31'd0, (i < n)});
      chk("done2_run", {31'd0, done2}, {31'd0, (i == n)});
    end
  endtask

  task automatic check_map2(input string name, input logic [127:0] exp);
    for (int k = 0; k < 4; k++) chk(name, gout2[k*32 +: 32], exp[k*32 +: 32]);
  endtask

  task automatic pass1(input logic [31:0] p, input logic [31:0] g, input logic [31:0] exp);
    pre1 = p; gin1 = g; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("busy1_accept", {31'd0, busy1}, 32'd1);
    chk("done1_accept", {31'd0, done1}, 32'd0);
    tick();
    chk("done1_end", {31'd0, done1}, 32'd1);
    chk("busy1_end", {31'd0, busy1}, 32'd0);
    chk("grad_out1", gout1, exp);
  endtask

  // ---------------- main stimulus ----------------
  initial begin : main
    logic [127:0] exp2;
    #1;
    rst1 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
    tick(); tick();
    rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    chk("busy2_reset", {31'd0, busy2}, 32'd0);
    chk("done2_reset", {31'd0, done2}, 32'd0);
    check_map2("grad_out2_reset", 128'd0);
    chk("grad_out1_reset", gout1, 32'd0);

    // Basic pass: pre={5,-3,0,7}, grad={10,20,30,-40}
    pre2 = {32'sd7, 32'sd0, -32'sd3, 32'sd5};
    gin2 = {-32'sd40, 32'sd30, 32'sd20, 32'sd10};
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("busy2_accept", {31'd0, busy2}, 32'd1);
    run2(4);
    exp2 = {32'hFFFF_FFD8, c_EXP_G30, c_EXP_G20, 32'd10};
    check_map2("grad_out2_basic", exp2);

    // Reset in the middle of a pass
    pre2 = {32'sd1, 32'sd1, 32'sd1, 32'sd1};
    gin2 = {32'sd44, 32'sd33, 32'sd22, 32'sd11};
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick(); tick();
    #2 rst2 = 1'b1;
    #1;
    chk("busy2_async_rst", {31'd0, busy2}, 32'd0);
    chk("done2_async_rst", {31'd0, done2}, 32'd0);
    check_map2("grad_out2_async_rst", 128'd0);
    tick();
    rst2 = 1'b0;
    tick(); tick();
    chk("busy2_idle_wait", {31'd0, busy2}, 32'd0);
    chk("done2_idle_wait", {31'd0, done2}, 32'd0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    run2(4);
    check_map2("grad_out2_after_rst", {32'd44, 32'd33, 32'd22, 32'd11});

    // start held high through the whole pass, then into DONE
    pre2 = {32'sd8, -32'sd7, 32'sd6, -32'sd5};
    gin2 = {32'sd19, 32'sd18, 32'sd17, -32'sd16};
    start2 = 1'b1;
    tick();
    run2(4);
    exp2 = {ref_grad(32'sd8, 32'sd19), ref_grad(-32'sd7, 32'sd18),
            ref_grad(32'sd6, 32'sd17), ref_grad(-32'sd5, -32'sd16)};
    check_map2("grad_out2_held_start", exp2);
    tick();
    start2 = 1'b0;
    chk("done2_restart", {31'd0, done2}, 32'd0);
    chk("busy2_restart", {31'd0, busy2}, 32'd1);
    run2(4);
    check_map2("grad_out2_back_to_back", exp2);

    // Single-element map corners
    pass1(32'h0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    pass1(32'h8000_0000, 32'h7FFF_FFFF, c_EXP_GMAX);
    pass1(32'hFFFF_FFFF, 32'hFFFF_FFF7, c_EXP_GM9);
    pass1(32'h0000_0000, 32'h1234_5678, ref_grad(32'sd0, 32'h1234_5678));

    // Randomized passes on the 16-element instance
    for (int p = 0; p < 100; p++) begin
      bit hold;
      int waited;
      for (int k = 0; k < c_N4; k++) begin
        pre4[k*32 +: 32] = rnd_val();
        gin4[k*32 +: 32] = rnd_val();
      end
      hold   = ($urandom_range(0, 3) == 0);
      start4 = 1'b1;
      tick();
      if (!hold) start4 = 1'b0;
      if (p % 17 == 5) begin
        repeat (5) @(posedge clk);
        #1;
        rst4   = 1'b1;
        start4 = 1'b0;
        tick();
        rst4 = 1'b0;
        continue;
      end
      waited = 0;
      while (!done4 && waited < 40) begin
        tick();
        waited++;
      end
      start4 = 1'b0;
      if (!done4) begin
        n_vec++;
        n_err++;
        $display("FAIL done4_timeout: pass %0d got no done within %0d cycles", p, waited);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
